// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: picks up to MAX_PER_LINE sprites overlapping the
// next line in priority order and issues one ROM row fetch per sprite.
//
// state | meaning
// IDLE  | waiting for line_start
// SCAN  | testing one table entry per cycle for a hit
// ISSUE | fetch request held until accepted
// CHECK | slots full; looking for one more hit to flag overflow
// DONE  | one-cycle done pulse, then back to IDLE
module sprite_line_scheduler #(
  parameter int NUM_SPR      = 16,
  parameter int SPR_H        = 32,
  parameter int MAX_PER_LINE = 4,
  parameter int COORD_W      = 10
) (
  input  logic                            clk_clk,
  input  logic                            reset_reset_n,
  input  logic                            line_start,
  input  logic [COORD_W-1:0]              next_line,
  input  logic [NUM_SPR-1:0]              spr_en,
  input  logic [NUM_SPR*COORD_W-1:0]      spr_x,
  input  logic [NUM_SPR*COORD_W-1:0]      spr_y,
  output logic                            fetch_valid,
  input  logic                            fetch_ready,
  output logic [$clog2(NUM_SPR)-1:0]      fetch_id,
  output logic [$clog2(SPR_H)-1:0]        fetch_row,
  output logic [COORD_W-1:0]              fetch_x,
  output logic [$clog2(MAX_PER_LINE)-1:0] fetch_slot,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow
);

  localparam int IDX_W  = $clog2(NUM_SPR);
  localparam int ROW_W  = $clog2(SPR_H);
  localparam int SLOT_W = $clog2(MAX_PER_LINE);

  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, CHECK, DONE} state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [SLOT_W-1:0]   slot;
  logic [COORD_W-1:0]  line_l;

  logic                cur_en;
  logic [COORD_W-1:0]  cur_x;
  logic [COORD_W-1:0]  cur_y;
  logic [COORD_W-1:0]  diff;
  logic                hit;
  logic                last_idx;
  logic                last_slot;
  logic                handshake;

  always_comb begin
    cur_en = 1'b0;
    cur_x  = '0;
    cur_y  = '0;
    for (int k = 0; k < NUM_SPR; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_en = spr_en[k];
        cur_x  = spr_x[k*COORD_W +: COORD_W];
        cur_y  = spr_y[k*COORD_W +: COORD_W];
      end
    end
  end

  // Modular subtraction: sprites starting below the line wrap to a large value.
  assign diff      = line_l - cur_y;
  assign hit       = cur_en && (diff < COORD_W'(SPR_H));
  assign last_idx  = (idx == IDX_W'(NUM_SPR-1));
  assign last_slot = (slot == SLOT_W'(MAX_PER_LINE-1));
  assign handshake = fetch_valid && fetch_ready;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      slot        <= '0;
      line_l      <= '0;
      fetch_valid <= 1'b0;
      fetch_id    <= '0;
      fetch_row   <= '0;
      fetch_x     <= '0;
      fetch_slot  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      // A new line always restarts the scan, discarding any pending request.
      if (line_start) begin
        state       <= SCAN;
        line_l      <= next_line;
        idx         <= '0;
        slot        <= '0;
        overflow    <= 1'b0;
        fetch_valid <= 1'b0;
        busy        <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          SCAN: begin
            if (hit) begin
              fetch_id    <= idx;
              fetch_row   <= diff[ROW_W-1:0];
              fetch_x     <= cur_x;
              fetch_slot  <= slot;
              fetch_valid <= 1'b1;
              state       <= ISSUE;
            end else if (last_idx) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          ISSUE: begin
            if (handshake) begin
              fetch_valid <= 1'b0;
              slot        <= slot + SLOT_W'(1);
              if (last_idx) begin
                done  <= 1'b1;
                state <= DONE;
              end else if (last_slot) begin
                idx   <= idx + IDX_W'(1);
                state <= CHECK;
              end else begin
                idx   <= idx + IDX_W'(1);
                state <= SCAN;
              end
            end
          end
          CHECK: begin
            if (hit) begin
              overflow <= 1'b1;
              done     <= 1'b1;
              state    <= DONE;
            end else if (last_idx) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler: table of single-line scans plus
// hand-written stall, abort and mid-scan reset sequences.
module tb_sprite_line_scheduler;

  localparam int NUM_SPR = 16;
  localparam int COORD_W = 10;

  logic                       clk_clk = 1'b0;
  logic                       reset_reset_n = 1'b0;
  logic                       line_start = 1'b0;
  logic [COORD_W-1:0]         next_line = '0;
  logic [NUM_SPR-1:0]         spr_en = '0;
  logic [NUM_SPR*COORD_W-1:0] spr_x = '0;
  logic [NUM_SPR*COORD_W-1:0] spr_y = '0;
  logic                       fetch_valid;
  logic                       fetch_ready = 1'b0;
  logic [3:0]                 fetch_id;
  logic [4:0]                 fetch_row;
  logic [COORD_W-1:0]         fetch_x;
  logic [1:0]                 fetch_slot;
  logic                       busy;
  logic                       done;
  logic                       overflow;

  sprite_line_scheduler dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .line_start   (line_start),
    .next_line    (next_line),
    .spr_en       (spr_en),
    .spr_x        (spr_x),
    .spr_y        (spr_y),
    .fetch_valid  (fetch_valid),
    .fetch_ready  (fetch_ready),
    .fetch_id     (fetch_id),
    .fetch_row    (fetch_row),
    .fetch_x      (fetch_x),
    .fetch_slot   (fetch_slot),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow)
  );

  always #5 clk_clk = ~clk_clk;

  int errors = 0;
  int checks = 0;
  int hs_count = 0;

  always @(posedge clk_clk) if (fetch_valid && fetch_ready) hs_count++;

  typedef struct {
    logic [15:0] en;
    logic [15:0] mask;   // sprites in mask get y=ya, all others y=yb
    int          ya;
    int          yb;
    int          line;
    int          n;
    logic [15:0] ids;    // expected ids in fetch order, 4 bits each
    int          row;
    int          done_c;
    int          ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int xpos(input int i);
    return i * 37 + 5;
  endfunction

  task automatic set_table(input logic [15:0] en, input logic [15:0] mask, input int ya, input int yb);
    spr_en = en;
    for (int i = 0; i < NUM_SPR; i++) begin
      spr_x[i*COORD_W +: COORD_W] = COORD_W'(xpos(i));
      spr_y[i*COORD_W +: COORD_W] = mask[i] ? COORD_W'(ya) : COORD_W'(yb);
    end
  endtask

  task automatic start_line(input int line);
    @(negedge clk_clk);
    next_line  = COORD_W'(line);
    line_start = 1'b1;
    @(posedge clk_clk);
    #1 line_start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int w;
    w = 0;
    @(negedge clk_clk);
    while (!fetch_valid && w < 40) begin
      w++;
      @(negedge clk_clk);
    end
    chk(name, fetch_valid, 1);
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    int nf, done_c, ndone, busy_c;
    nf = 0; done_c = 0; ndone = 0; busy_c = 0;
    set_table(v.en, v.mask, v.ya, v.yb);
    fetch_ready = 1'b1;
    start_line(v.line);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_clk);
      if (c == 1) chk($sformatf("v%0d_ovf_clear", vi), overflow, 0);
      if (busy) busy_c++;
      if (done) begin
        ndone++;
        if (done_c == 0) done_c = c;
      end
      if (fetch_valid) begin
        if (nf < 4) begin
          chk($sformatf("v%0d_id%0d", vi, nf), fetch_id, v.ids[nf*4 +: 4]);
          chk($sformatf("v%0d_row%0d", vi, nf), fetch_row, v.row);
          chk($sformatf("v%0d_x%0d", vi, nf), fetch_x, xpos(int'(v.ids[nf*4 +: 4])));
          chk($sformatf("v%0d_slot%0d", vi, nf), fetch_slot, nf);
        end
        nf++;
      end
    end
    chk($sformatf("v%0d_nfetch", vi), nf, v.n);
    chk($sformatf("v%0d_done_cycle", vi), done_c, v.done_c);
    chk($sformatf("v%0d_done_count", vi), ndone, 1);
    chk($sformatf("v%0d_busy_cycles", vi), busy_c, v.done_c);
    chk($sformatf("v%0d_overflow", vi), overflow, v.ovf);
  endtask

  initial begin
    int hs0, ndone, done_c;

    //           en        mask      ya    yb   line n  ids       row done ovf
    vecs[0] = '{16'h0000, 16'h0000, 0,    100, 100, 0, 16'h0000, 0,  17, 0};
    vecs[1] = '{16'h0008, 16'h0008, 90,   0,   100, 1, 16'h0003, 10, 18, 0};
    vecs[2] = '{16'h02A5, 16'hFFFF, 100,  100, 110, 4, 16'h7520, 10, 15, 1};
    vecs[3] = '{16'h0010, 16'h0010, 120,  100, 100, 0, 16'h0000, 0,  17, 0};
    vecs[4] = '{16'hA000, 16'h2000, 99,   100, 131, 1, 16'h000F, 31, 18, 0};
    vecs[5] = '{16'h0001, 16'h0001, 1020, 0,   5,   1, 16'h0000, 9,  18, 0};
    vecs[6] = '{16'h014A, 16'hFFFF, 100,  100, 100, 4, 16'h8631, 0,  21, 0};

    #12;
    chk("rst_valid", fetch_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_fields", {fetch_id, fetch_row, fetch_x, fetch_slot}, 0);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;

    for (int vi = 0; vi < 7; vi++) run_vec(vecs[vi], vi);

    // Stall: sprites 1 and 4 hit; first request held 5 cycles by fetch_ready low.
    set_table(16'h0012, 16'hFFFF, 100, 100);
    fetch_ready = 1'b0;
    start_line(100);
    wait_valid("stall_reach");
    hs0 = hs_count;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk_clk);
      chk($sformatf("stall_valid_k%0d", k), fetch_valid, 1);
      chk($sformatf("stall_id_k%0d", k), fetch_id, 1);
      chk($sformatf("stall_row_k%0d", k), fetch_row, 0);
      chk($sformatf("stall_x_k%0d", k), fetch_x, xpos(1));
      chk($sformatf("stall_slot_k%0d", k), fetch_slot, 0);
    end
    fetch_ready = 1'b1;
    @(negedge clk_clk);
    chk("stall_valid_drop", fetch_valid, 0);
    chk("stall_one_handshake", hs_count - hs0, 1);
    wait_valid("stall_second_reach");
    chk("stall_second_id", fetch_id, 4);
    chk("stall_second_slot", fetch_slot, 1);
    @(negedge clk_clk);
    chk("stall_two_handshakes", hs_count - hs0, 2);
    repeat (20) @(negedge clk_clk);
    chk("stall_idle", busy, 0);

    // Abort: restart during a stalled ISSUE with an empty table.
    set_table(16'h0002, 16'hFFFF, 100, 100);
    fetch_ready = 1'b0;
    start_line(100);
    wait_valid("abort_reach");
    hs0 = hs_count;
    set_table(16'h0000, 16'hFFFF, 100, 100);
    start_line(100);
    ndone = 0; done_c = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_clk);
      if (c == 1) chk("abort_valid_drop", fetch_valid, 0);
      if (done) begin
        ndone++;
        if (done_c == 0) done_c = c;
      end
    end
    chk("abort_done_cycle", done_c, 17);
    chk("abort_done_count", ndone, 1);
    chk("abort_no_handshake", hs_count - hs0, 0);

    // Asynchronous reset in the middle of ISSUE.
    set_table(16'h0002, 16'hFFFF, 100, 100);
    fetch_ready = 1'b0;
    start_line(100);
    wait_valid("reset_reach");
    #2 reset_reset_n = 1'b0;
    #1;
    chk("areset_valid", fetch_valid, 0);
    chk("areset_busy", busy, 0);
    chk("areset_fields", {fetch_id, fetch_row, fetch_x, fetch_slot, done, overflow}, 0);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_clk);
      if (busy || fetch_valid || done) ndone++;
    end
    chk("areset_idle_after", ndone, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
